// File: rtl/arith_pipeline_v2_if.sv
// Token, LUT-load and status signals of arith_pipeline_v2.
// The slave modport is the pipeline's view; master is the driver's view.
interface arith_pipeline_v2_if #(
   parameter int DW     = 16,
   parameter int LUT_AW = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_mode;
   logic [DW-1:0]     in_data;
   logic [DW-1:0]     in_psum;
   logic              acc_clr;
   logic              lut_we;
   logic [1:0]        lut_sel;
   logic [LUT_AW-1:0] lut_addr;
   logic [DW-1:0]     lut_wdata;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_mode;
   logic [DW-1:0]     acc_value;

   modport master (
      output in_valid, in_mode, in_data, in_psum, acc_clr,
             lut_we, lut_sel, lut_addr, lut_wdata, out_ready,
      input  in_ready, out_valid, out_data, out_mode, acc_value
   );

   modport slave (
      input  in_valid, in_mode, in_data, in_psum, acc_clr,
             lut_we, lut_sel, lut_addr, lut_wdata, out_ready,
      output in_ready, out_valid, out_data, out_mode, acc_value
   );
endinterface

// File: rtl/arith_pipeline_v2.sv
// Two-stage saturating fixed-point pipeline: exp-accumulate, normalise,
// activation LUT and weighted aggregation, with valid/ready backpressure.
module arith_pipeline_v2 #(
   parameter int DW      = 16,
   parameter int FRAC    = 8,
   parameter int LUT_AW  = 8,
   parameter int NUM_EXP = 8
) (
   input logic               clk,
   input logic               rst,
   arith_pipeline_v2_if.slave bus
);
   localparam int IW    = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
   localparam int LUT_N = 1 << LUT_AW;
   localparam int SW    = DW + 1;
   localparam int PW    = 2 * DW;

   localparam logic signed [DW-1:0] MAX_VAL  = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] MIN_VAL  = {1'b1, {(DW-1){1'b0}}};
   localparam logic        [DW-1:0] RIDX_MAX = DW'(LUT_N - 1);
   localparam logic        [IW-1:0] IDX_LAST = IW'(NUM_EXP - 1);

   typedef enum logic [1:0] {
      MODE_EXP_ACC = 2'd0,
      MODE_NORM    = 2'd1,
      MODE_ACT     = 2'd2,
      MODE_AGG     = 2'd3
   } mode_e;

   function automatic logic signed [DW-1:0] sat_add(input logic signed [DW-1:0] a,
                                                    input logic signed [DW-1:0] b);
      logic signed [SW-1:0] sum;
      sum = SW'(a) + SW'(b);
      if (sum[SW-1] != sum[SW-2]) return sum[SW-1] ? MIN_VAL : MAX_VAL;
      return sum[DW-1:0];
   endfunction

   // Arithmetic shift of the full product floors toward -inf; overflow shows as
   // upper bits that are not all copies of the sign.
   function automatic logic signed [DW-1:0] sat_mul(input logic signed [DW-1:0] a,
                                                    input logic signed [DW-1:0] b);
      logic signed [PW-1:0] prod;
      prod = (PW'(a) * PW'(b)) >>> FRAC;
      if (prod[PW-1:DW-1] != {(DW+1){prod[PW-1]}}) return prod[PW-1] ? MIN_VAL : MAX_VAL;
      return prod[DW-1:0];
   endfunction

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
      return (idx == IDX_LAST) ? '0 : idx + 1'b1;
   endfunction

   logic signed [DW-1:0] exp_lut    [LUT_N];
   logic signed [DW-1:0] recip_lut  [LUT_N];
   logic signed [DW-1:0] act_lut    [LUT_N];
   logic signed [DW-1:0] weight_mem [NUM_EXP];

   logic                 s1_valid;
   mode_e                s1_mode;
   logic signed [DW-1:0] s1_data;
   logic signed [DW-1:0] s1_psum;

   logic signed [DW-1:0] acc;
   logic [IW-1:0]        wr_idx;
   logic [IW-1:0]        rd_idx;

   logic                 out_valid_q;
   logic [DW-1:0]        out_data_q;
   logic [1:0]           out_mode_q;

   logic                 stall;
   logic                 s2_fire;
   logic                 s2_emits;
   logic [LUT_AW-1:0]    lut_idx;
   logic [LUT_AW-1:0]    ridx;
   logic [DW-1:0]        acc_int;
   logic signed [DW-1:0] exp_sum;
   logic signed [DW-1:0] norm_r;
   logic signed [DW-1:0] agg_r;
   logic signed [DW-1:0] result;

   assign stall         = out_valid_q && !bus.out_ready;
   assign s2_fire       = s1_valid && !stall;
   assign s2_emits      = s1_valid && (s1_mode != MODE_EXP_ACC);
   assign bus.in_ready  = !stall;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_mode  = out_mode_q;
   assign bus.acc_value = acc;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
   always_comb begin
      lut_idx = s1_data[LUT_AW-1:0];
      acc_int = {{FRAC{1'b0}}, acc[DW-1:FRAC]};
      ridx    = '0;
      if (!acc[DW-1]) ridx = (acc_int > RIDX_MAX) ? '1 : acc_int[LUT_AW-1:0];
      exp_sum = sat_add(acc, exp_lut[lut_idx]);
      norm_r  = sat_mul(recip_lut[ridx], s1_data);
      agg_r   = sat_add(s1_psum, sat_mul(weight_mem[rd_idx], s1_data));
      result  = '0;
      case (s1_mode)
         MODE_NORM: result = norm_r;
         MODE_ACT:  result = act_lut[lut_idx];
         MODE_AGG:  result = agg_r;
         default:   result = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_mode     <= MODE_EXP_ACC;
         s1_data     <= '0;
         s1_psum     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mode_q  <= '0;
      end else if (!stall) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_mode <= mode_e'(bus.in_mode);
            s1_data <= bus.in_data;
            s1_psum <= bus.in_psum;
         end
         out_valid_q <= s2_emits;
         if (s2_emits) begin
            out_data_q <= result;
            out_mode_q <= s1_mode;
         end
      end
   end

   // A clear overrides whatever the S2 token would have done to acc or an index.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         wr_idx <= '0;
         rd_idx <= '0;
      end else if (!stall) begin
         if (bus.acc_clr) begin
            acc    <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
         end else if (s1_valid) begin
            case (s1_mode)
               MODE_EXP_ACC: acc    <= exp_sum;
               MODE_NORM:    wr_idx <= next_idx(wr_idx);
               MODE_AGG:     rd_idx <= next_idx(rd_idx);
               default:      ;
            endcase
         end
      end
   end

   // NOTE: LUT and weight arrays are plain storage without reset; software loads them before use.
   always_ff @(posedge clk) begin
      if (!rst && s2_fire && s1_mode == MODE_NORM) weight_mem[wr_idx] <= norm_r;
   end

   always_ff @(posedge clk) begin
      if (bus.lut_we) begin
         case (bus.lut_sel)
            2'd0:    exp_lut[bus.lut_addr]   <= bus.lut_wdata;
            2'd1:    recip_lut[bus.lut_addr] <= bus.lut_wdata;
            2'd2:    act_lut[bus.lut_addr]   <= bus.lut_wdata;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_arith_pipeline_v2.sv
// Directed self-checking bench for arith_pipeline_v2 with hand-computed
// Q8.8 expectations, including saturation, backpressure, wrap and reset.
module tb_arith_pipeline_v2;
   logic clk;
   logic rst;
   int   n_pass = 0;
   int   n_fail = 0;
   int   n_total = 0;

   arith_pipeline_v2_if #(.DW(16), .LUT_AW(8)) bus ();

   arith_pipeline_v2 #(
      .DW(16), .FRAC(8), .LUT_AW(8), .NUM_EXP(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_total++;
      assert (observed === expected) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lut_write(input logic [1:0] sel, input logic [7:0] addr, input logic [15:0] data);
      bus.lut_we    = 1'b1;
      bus.lut_sel   = sel;
      bus.lut_addr  = addr;
      bus.lut_wdata = data;
      tick();
      bus.lut_we    = 1'b0;
   endtask

   task automatic send(input logic [1:0] mode, input logic [15:0] data, input logic [15:0] psum);
      bus.in_valid = 1'b1;
      bus.in_mode  = mode;
      bus.in_data  = data;
      bus.in_psum  = psum;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic clear();
      bus.acc_clr = 1'b1;
      tick();
      bus.acc_clr = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [1:0] mode, input logic [15:0] data);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_mode"},  32'(bus.out_mode),  32'(mode));
      check({tag, "_data"},  32'(bus.out_data),  32'(data));
   endtask

   logic [15:0] bp_exp [5] = '{16'h1000, 16'h1111, 16'h1222, 16'h1333, 16'h1444};
   int idx, got, stalls, ready_err;

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_mode = 2'd0; bus.in_data = '0; bus.in_psum = '0;
      bus.acc_clr = 1'b0; bus.lut_we = 1'b0; bus.lut_sel = 2'd0; bus.lut_addr = '0;
      bus.lut_wdata = '0; bus.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_out_mode",  32'(bus.out_mode),  32'd0);
      check("rst_acc",       32'(bus.acc_value), 32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);

      lut_write(2'd0, 8'd3,  16'h0200);
      lut_write(2'd0, 8'd5,  16'h0100);
      lut_write(2'd1, 8'd3,  16'h0055);
      lut_write(2'd1, 8'd0,  16'h0400);
      lut_write(2'd2, 8'd7,  16'h0777);
      lut_write(2'd2, 8'd20, 16'h0020);
      for (int i = 0; i < 5; i++) lut_write(2'd2, 8'(10 + i), bp_exp[i]);
      lut_write(2'd3, 8'd7,  16'hDEAD);

      // Exp-accumulate then normalise: acc 0x300 -> recip[3]=0x55
      clear();
      send(2'd0, 16'd3, 16'd0);
      send(2'd0, 16'd5, 16'd0);
      tick();
      check("exp_acc_value", 32'(bus.acc_value), 32'h0300);
      check("exp_no_out",    32'(bus.out_valid), 32'd0);
      send(2'd1, 16'h0200, 16'd0);
      tick();
      check_out("norm_w0", 2'd1, 16'h00AA);
      send(2'd1, 16'h0100, 16'd0);
      tick();
      check_out("norm_w1", 2'd1, 16'h0055);
      send(2'd1, 16'hFFFF, 16'd0);
      tick();
      check_out("norm_floor", 2'd1, 16'hFFFF);
      tick();
      check("bubble_no_out", 32'(bus.out_valid), 32'd0);

      // Aggregation reads weight[0] then weight[1]
      clear();
      send(2'd3, 16'h0200, 16'h0100);
      send(2'd3, 16'h0200, 16'h0000);
      check_out("agg_w0", 2'd3, 16'h0254);
      tick();
      check_out("agg_w1", 2'd3, 16'h00AA);

      // Saturation
      clear();
      send(2'd1, 16'h0100, 16'd0);
      tick();
      check_out("norm_r0", 2'd1, 16'h0400);
      send(2'd3, 16'h7FFF, 16'h0100);
      tick();
      check_out("agg_sat_pos", 2'd3, 16'h7FFF);
      clear();
      send(2'd3, 16'hFF00, 16'h8000);
      tick();
      check_out("agg_sat_neg", 2'd3, 16'h8000);

      // Activation LUT: lut_sel=3 writes nothing; same-cycle write returns old value
      send(2'd2, 16'd7, 16'd0);
      tick();
      check_out("act_sel3", 2'd2, 16'h0777);
      send(2'd2, 16'd20, 16'd0);
      lut_write(2'd2, 8'd20, 16'h0999);
      check_out("act_old_val", 2'd2, 16'h0020);
      send(2'd2, 16'd20, 16'd0);
      tick();
      check_out("act_new_val", 2'd2, 16'h0999);
      tick();

      // Backpressure: out_ready low for cycles 3..5 of the stream
      idx = 0; got = 0; stalls = 0; ready_err = 0;
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         bus.out_ready = !(cyc >= 3 && cyc < 6);
         bus.in_valid  = (idx < 5);
         bus.in_mode   = 2'd2;
         bus.in_data   = 16'(10 + idx);
         bus.in_psum   = '0;
         #1;
         if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) ready_err++;
         if (!bus.in_ready) stalls++;
         if (bus.out_valid && bus.out_ready) begin
            check($sformatf("bp_data%0d", got), 32'(bus.out_data), 32'(bp_exp[got]));
            got++;
         end
         if (bus.in_valid && bus.in_ready) idx++;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("bp_outputs",   32'(got),       32'd5);
      check("bp_accepted",  32'(idx),       32'd5);
      check("bp_stalls",    32'(stalls),    32'd3);
      check("bp_ready_rel", 32'(ready_err), 32'd0);
      tick();
      tick();
      check("bp_no_dup", 32'(bus.out_valid), 32'd0);

      // Weight index wrap: 9 NORM tokens, 4*(i+1) each; the ninth lands in weight[0]
      clear();
      for (int i = 0; i < 9; i++) send(2'd1, 16'(i + 1), 16'd0);
      tick();
      check_out("wrap_last", 2'd1, 16'h0024);

      // Clear coinciding with a mode-0 token in S2
      clear();
      send(2'd0, 16'd3, 16'd0);
      tick();
      check("clr_pre_acc", 32'(bus.acc_value), 32'h0200);
      send(2'd0, 16'd5, 16'd0);
      bus.acc_clr = 1'b1;
      tick();
      bus.acc_clr = 1'b0;
      check("clr_wins_acc", 32'(bus.acc_value), 32'd0);

      // Clear coinciding with an AGG advance resets rd_idx
      send(2'd3, 16'h0100, 16'd0);
      tick();
      check_out("agg_wrap_w0", 2'd3, 16'h0024);
      send(2'd3, 16'h0100, 16'd0);
      bus.acc_clr = 1'b1;
      tick();
      bus.acc_clr = 1'b0;
      check_out("agg_clr_w1", 2'd3, 16'h0008);
      send(2'd3, 16'h0100, 16'd0);
      tick();
      check_out("clr_wins_idx", 2'd3, 16'h0024);

      // Reset with tokens in S1 and the output stage
      send(2'd0, 16'd3, 16'd0);
      tick();
      check("pre_rst_acc", 32'(bus.acc_value), 32'h0200);
      send(2'd2, 16'd7, 16'd0);
      send(2'd2, 16'd20, 16'd0);
      check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_out_data",  32'(bus.out_data),  32'd0);
      check("mid_rst_out_mode",  32'(bus.out_mode),  32'd0);
      check("mid_rst_acc",       32'(bus.acc_value), 32'd0);
      tick();
      check("post_rst_no_out", 32'(bus.out_valid), 32'd0);
      send(2'd3, 16'h0100, 16'd0);
      tick();
      check_out("post_rst_rd0", 2'd3, 16'h0024);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
